// File: rtl/fp_mul_iter_if.sv
// Request/response bundle for the iterative binary64 multiplier.
// The requester (master) drives valid/a/b. The responder (slave) returns
// result/flags with a one-cycle finish pulse and reports busy while working.
interface fp_mul_iter_if #(
    parameter int DBL_WIDTH = 64
);
    logic                 valid;
    logic [DBL_WIDTH-1:0] a;
    logic [DBL_WIDTH-1:0] b;
    logic [DBL_WIDTH-1:0] result;
    logic                 finish;
    logic                 busy;
    logic [2:0]           flags;   // {invalid, overflow, underflow}

    modport master (
        output valid, a, b,
        input  result, finish, busy, flags
    );

    modport slave (
        input  valid, a, b,
        output result, finish, busy, flags
    );
endinterface

// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754 binary64 multiplier.
// A single radix-2 shift-add engine forms the 106-bit mantissa product over
// 53 cycles. Normalise and round each take one more cycle, so every request
// finishes a fixed 57 cycles after valid, whatever the operand class.
// Subnormal inputs are read as zero, and results that underflow flush to zero.
module fp_mul_iter #(
    parameter int DBL_WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_mul_iter_if.slave  bus
);

    // Only binary64 is implemented. Any other width stops elaboration.
    generate
        if (DBL_WIDTH != 64) begin : g_width_check
            $error("fp_mul_iter supports only DBL_WIDTH = 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MUL,
        S_NORM,
        S_ROUND
    } state_t;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [63:0]          a_q, a_d;
    logic [63:0]          b_q, b_d;
    logic                 sign_q, sign_d;
    logic                 invalid_q, invalid_d;   // NaN input, or inf x 0
    logic                 inf_q, inf_d;           // inf x nonzero
    logic                 zero_q, zero_d;         // zero (or flushed subnormal) x finite
    logic signed [12:0]   exp_q, exp_d;           // biased exponent, holds ea+eb until NORM
    logic [105:0]         mcand_q, mcand_d;       // multiplicand, shifted left once per step
    logic [52:0]          mplier_q, mplier_d;     // multiplier, shifted right once per step
    logic [105:0]         acc_q, acc_d;           // product accumulator
    logic [5:0]           cnt_q, cnt_d;           // step counter, 0..52
    logic [52:0]          mant_q, mant_d;         // normalised mantissa, hidden bit included
    logic                 guard_q, guard_d;
    logic                 rnd_q, rnd_d;
    logic                 sticky_q, sticky_d;
    logic [63:0]          result_q, result_d;
    logic [2:0]           flags_q, flags_d;
    logic                 finish_q, finish_d;
    logic                 busy_q, busy_d;

    // ------------------------------------------------------------------
    // Operand fields and classification (taken from the latched operands)
    // ------------------------------------------------------------------
    logic [10:0] ea, eb;
    logic [51:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea     = a_q[62:52];
    assign eb     = b_q[62:52];
    assign fa     = a_q[51:0];
    assign fb     = b_q[51:0];
    assign a_zero = (ea == 11'd0);
    assign b_zero = (eb == 11'd0);
    assign a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
    assign b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
    assign a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
    assign b_nan  = (eb == 11'h7FF) && (fb != 52'd0);

    // ------------------------------------------------------------------
    // Round-to-nearest-even on the normalised mantissa. A carry out of the
    // mantissa leaves 1.000..0, so the result shifts right one place and the
    // exponent goes up by one.
    // ------------------------------------------------------------------
    logic                round_up;
    logic [53:0]         mant_rnd;
    logic signed [12:0]  exp_rnd;
    logic [51:0]         frac_rnd;

    // Rounded mantissa and exponent, used in the S_ROUND cycle
    always_comb begin
        round_up = guard_q & (rnd_q | sticky_q | mant_q[0]);
        mant_rnd = {1'b0, mant_q} + {53'd0, round_up};
        if (mant_rnd[53]) begin
            frac_rnd = mant_rnd[52:1];
            exp_rnd  = exp_q + 13'sd1;
        end else begin
            frac_rnd = mant_rnd[51:0];
            exp_rnd  = exp_q;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic for the whole sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        invalid_d = invalid_q;
        inf_d     = inf_q;
        zero_d    = zero_q;
        exp_d     = exp_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mant_d    = mant_q;
        guard_d   = guard_q;
        rnd_d     = rnd_q;
        sticky_d  = sticky_q;
        result_d  = result_q;
        flags_d   = flags_q;
        finish_d  = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                // A request is accepted only here. This includes the cycle
                // in which the previous finish is high.
                if (bus.valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end

            S_UNPACK: begin
                sign_d    = a_q[63] ^ b_q[63];
                invalid_d = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                inf_d     = a_inf | b_inf;
                zero_d    = a_zero | b_zero;
                exp_d     = {2'b00, ea} + {2'b00, eb};
                mcand_d   = {53'd0, (a_zero ? 53'd0 : {1'b1, fa})};
                mplier_d  = b_zero ? 53'd0 : {1'b1, fb};
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = S_MUL;
            end

            S_MUL: begin
                // One partial product per cycle. Bit cnt of the multiplier is
                // always at mplier_q[0], and the multiplicand is already
                // shifted left by cnt.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = {mcand_q[104:0], 1'b0};
                mplier_d = {1'b0, mplier_q[52:1]};
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd52) begin
                    state_d = S_NORM;
                end
            end

            S_NORM: begin
                // The product of two 1.x mantissas lies in [1, 4), so at most
                // one position of normalisation shift is needed.
                if (acc_q[105]) begin
                    mant_d   = acc_q[105:53];
                    guard_d  = acc_q[52];
                    rnd_d    = acc_q[51];
                    sticky_d = |acc_q[50:0];
                    exp_d    = exp_q - 13'sd1022;
                end else begin
                    mant_d   = acc_q[104:52];
                    guard_d  = acc_q[51];
                    rnd_d    = acc_q[50];
                    sticky_d = |acc_q[49:0];
                    exp_d    = exp_q - 13'sd1023;
                end
                state_d = S_ROUND;
            end

            S_ROUND: begin
                flags_d = 3'b000;
                if (invalid_q) begin
                    result_d = QNAN;
                    flags_d  = 3'b100;
                end else if (inf_q) begin
                    result_d = {sign_q, 11'h7FF, 52'd0};
                end else if (zero_q) begin
                    result_d = {sign_q, 63'd0};
                end else if (exp_rnd >= 13'sd2047) begin
                    result_d = {sign_q, 11'h7FF, 52'd0};
                    flags_d  = 3'b010;
                end else if (exp_rnd <= 13'sd0) begin
                    result_d = {sign_q, 63'd0};
                    flags_d  = 3'b001;
                end else begin
                    result_d = {sign_q, exp_rnd[10:0], frac_rnd};
                end
                finish_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // All state, with an asynchronous reset that also aborts a request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            invalid_q <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
            exp_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mant_q    <= '0;
            guard_q   <= 1'b0;
            rnd_q     <= 1'b0;
            sticky_q  <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            finish_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            invalid_q <= invalid_d;
            inf_q     <= inf_d;
            zero_q    <= zero_d;
            exp_q     <= exp_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mant_q    <= mant_d;
            guard_q   <= guard_d;
            rnd_q     <= rnd_d;
            sticky_q  <= sticky_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            finish_q  <= finish_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.finish = finish_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Testbench for fp_mul_iter.
// Checks directed and random requests against a behavioural reference model.
// Cycle 0 is the cycle in which valid is high. Outputs are sampled 1 time
// unit after each rising edge.
module tb_fp_mul_iter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    fp_mul_iter_if #(.DBL_WIDTH(64)) bus ();

    fp_mul_iter #(.DBL_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. The binary64 product comes from the host's
    // round-to-nearest-even real multiply. The block's own rules are then
    // applied on top: subnormal inputs read as zero, NaN and inf classes
    // handled first, and results below the normal range flush to zero.
    function automatic void ref_mul(input logic [63:0] x, input logic [63:0] y,
                                    output logic [63:0] r, output logic [2:0] f);
        logic        s;
        logic        xz, yz, xi, yi, xn, yn;
        real         p;
        logic [63:0] pb;
        s  = x[63] ^ y[63];
        xz = (x[62:52] == 11'd0);
        yz = (y[62:52] == 11'd0);
        xi = (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
        yi = (y[62:52] == 11'h7FF) && (y[51:0] == 52'd0);
        xn = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
        yn = (y[62:52] == 11'h7FF) && (y[51:0] != 52'd0);
        f  = 3'b000;
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            r = 64'h7FF8_0000_0000_0000;
            f = 3'b100;
        end else if (xi || yi) begin
            r = {s, 11'h7FF, 52'd0};
        end else if (xz || yz) begin
            r = {s, 63'd0};
        end else begin
            p  = $bitstoreal({1'b0, x[62:0]}) * $bitstoreal({1'b0, y[62:0]});
            pb = $realtobits(p);
            if (pb[62:52] == 11'h7FF) begin
                r = {s, 11'h7FF, 52'd0};
                f = 3'b010;
            end else if (pb[62:52] == 11'd0) begin
                r = {s, 63'd0};
                f = 3'b001;
            end else begin
                r = {s, pb[62:0]};
            end
        end
    endfunction

    // Random operand, biased towards normal numbers near 1.0 and including
    // every special class
    function automatic logic [63:0] rand_operand();
        logic [51:0] fr;
        int unsigned k;
        fr = {$urandom, $urandom};
        k  = $urandom_range(0, 15);
        case (k)
            0:       return {1'($urandom), 63'd0};
            1:       return {1'($urandom), 11'd0, fr | 52'd1};
            2:       return {1'($urandom), 11'h7FF, 52'd0};
            3:       return {1'($urandom), 11'h7FF, fr | 52'd1};
            4, 5, 6: return {1'($urandom), 11'($urandom_range(1, 2046)), fr};
            default: return {1'($urandom), 11'($urandom_range(900, 1150)), fr};
        endcase
    endfunction

    // Drive one request and wait, with a bound, for its finish. lat is -1 if
    // no finish arrives.
    task automatic do_op(input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic [2:0] f, output int lat);
        lat = -1;
        @(posedge clk); #1;
        bus.valid = 1'b1;
        bus.a     = x;
        bus.b     = y;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.valid = 1'b0;
            if (bus.finish === 1'b1) begin
                lat = n;
                break;
            end
        end
        r = bus.result;
        f = bus.flags;
        $display("op a=%016h b=%016h -> result=%016h flags=%03b latency=%0d", x, y, r, f, lat);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.valid = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.result !== 64'd0) $display("FAIL reset_result got=%016h want=0", bus.result); else n_pass++;
        n_checks++; if (bus.finish !== 1'b0) $display("FAIL reset_finish got=%b want=0", bus.finish); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else n_pass++;
        n_checks++; if (bus.flags !== 3'b000) $display("FAIL reset_flags got=%03b want=000", bus.flags); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // 1.5 x 2.0: latency, busy window, one-cycle finish, held result
    task automatic test_basic();
        int          fin_count;
        int          fin_cycle;
        int          busy_bad;
        logic [63:0] res57;
        logic [2:0]  flg57;
        fin_count = 0; fin_cycle = -1; busy_bad = 0;
        res57 = 'x; flg57 = 'x;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_c0 got=%b want=0", bus.busy); else n_pass++;
        bus.valid = 1'b1;
        bus.a     = 64'h3FF8_0000_0000_0000;
        bus.b     = 64'h4000_0000_0000_0000;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.valid = 1'b0;
            if ((n <= 56) !== bus.busy) busy_bad++;
            if (bus.finish === 1'b1) begin
                fin_count++;
                if (fin_cycle < 0) fin_cycle = n;
            end
            if (n == 57) begin
                res57 = bus.result;
                flg57 = bus.flags;
            end
            if (n == 58) begin
                n_checks++; if (bus.finish !== 1'b0) $display("FAIL basic_finish_c58 got=%b want=0", bus.finish); else n_pass++;
                n_checks++; if (bus.result !== 64'h4008_0000_0000_0000) $display("FAIL basic_hold_c58 got=%016h want=4008000000000000", bus.result); else n_pass++;
            end
        end
        $display("op a=3ff8000000000000 b=4000000000000000 -> result=%016h flags=%03b finish_cycle=%0d", res57, flg57, fin_cycle);
        n_checks++; if (fin_cycle !== 57) $display("FAIL basic_latency got=%0d want=57", fin_cycle); else n_pass++;
        n_checks++; if (fin_count !== 1) $display("FAIL basic_finish_count got=%0d want=1", fin_count); else n_pass++;
        n_checks++; if (res57 !== 64'h4008_0000_0000_0000) $display("FAIL basic_result got=%016h want=4008000000000000", res57); else n_pass++;
        n_checks++; if (flg57 !== 3'b000) $display("FAIL basic_flags got=%03b want=000", flg57); else n_pass++;
        n_checks++; if (busy_bad !== 0) $display("FAIL basic_busy_window bad_cycles=%0d want=0", busy_bad); else n_pass++;
    endtask

    task automatic test_rounding();
        logic [63:0] ta [2] = '{64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001};
        logic [63:0] tb [2] = '{64'h3FF0_0000_0000_0001, 64'h3FF8_0000_0000_0000};
        logic [63:0] te [2] = '{64'h3FF0_0000_0000_0002, 64'h3FF8_0000_0000_0002};
        logic [63:0] r;
        logic [2:0]  f;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], tb[i], r, f, lat);
            n_checks++; if (r !== te[i]) $display("FAIL rounding_%0d got=%016h want=%016h", i, r, te[i]); else n_pass++;
            n_checks++; if (f !== 3'b000) $display("FAIL rounding_flags_%0d got=%03b want=000", i, f); else n_pass++;
        end
    endtask

    // Overflow, invalid, underflow, signed zero
    task automatic test_exceptions();
        logic [63:0] ta [4] = '{64'h7FE0_0000_0000_0000, 64'h7FF0_0000_0000_0000,
                                64'h0010_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] tb [4] = '{64'h4000_0000_0000_0000, 64'h0000_0000_0000_0000,
                                64'h3FE0_0000_0000_0000, 64'h4000_0000_0000_0000};
        logic [63:0] te [4] = '{64'h7FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000,
                                64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [2:0]  tf [4] = '{3'b010, 3'b100, 3'b001, 3'b000};
        logic [63:0] r;
        logic [2:0]  f;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], r, f, lat);
            n_checks++; if (r !== te[i]) $display("FAIL exception_result_%0d got=%016h want=%016h", i, r, te[i]); else n_pass++;
            n_checks++; if (f !== tf[i]) $display("FAIL exception_flags_%0d got=%03b want=%03b", i, f, tf[i]); else n_pass++;
            n_checks++; if (lat !== 57) $display("FAIL exception_latency_%0d got=%0d want=57", i, lat); else n_pass++;
        end
    endtask

    // A second valid while busy is dropped
    task automatic test_ignored_valid();
        int          fin_count;
        int          fin_cycle;
        logic [63:0] res;
        fin_count = 0; fin_cycle = -1; res = 'x;
        @(posedge clk); #1;
        bus.valid = 1'b1;
        bus.a     = 64'h3FF8_0000_0000_0000;
        bus.b     = 64'h4000_0000_0000_0000;
        for (int n = 1; n <= 130; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.valid = 1'b0;
            if (n == 10) begin
                bus.valid = 1'b1;
                bus.a     = 64'h4010_0000_0000_0000;
                bus.b     = 64'h4014_0000_0000_0000;
            end
            if (n == 11) bus.valid = 1'b0;
            if (bus.finish === 1'b1) begin
                fin_count++;
                if (fin_cycle < 0) begin
                    fin_cycle = n;
                    res = bus.result;
                end
            end
        end
        $display("op ignored-valid: finishes=%0d first_cycle=%0d result=%016h", fin_count, fin_cycle, res);
        n_checks++; if (fin_count !== 1) $display("FAIL ignored_finish_count got=%0d want=1", fin_count); else n_pass++;
        n_checks++; if (fin_cycle !== 57) $display("FAIL ignored_finish_cycle got=%0d want=57", fin_cycle); else n_pass++;
        n_checks++; if (res !== 64'h4008_0000_0000_0000) $display("FAIL ignored_result got=%016h want=4008000000000000", res); else n_pass++;
    endtask

    // A valid in the finish cycle starts the next operation at once
    task automatic test_back_to_back();
        int          fin_count;
        int          c1, c2;
        logic [63:0] r1, r2;
        fin_count = 0; c1 = -1; c2 = -1; r1 = 'x; r2 = 'x;
        @(posedge clk); #1;
        bus.valid = 1'b1;
        bus.a     = 64'h3FF8_0000_0000_0000;
        bus.b     = 64'h4000_0000_0000_0000;
        for (int n = 1; n <= 130; n++) begin
            @(posedge clk); #1;
            if (n == 1 || n == 58) bus.valid = 1'b0;
            if (bus.finish === 1'b1) begin
                fin_count++;
                if (c1 < 0) begin
                    c1 = n; r1 = bus.result;
                end else if (c2 < 0) begin
                    c2 = n; r2 = bus.result;
                end
            end
            if (n == 57) begin
                bus.valid = 1'b1;
                bus.a     = 64'h3FF0_0000_0000_0001;
                bus.b     = 64'h3FF8_0000_0000_0000;
            end
        end
        $display("op back-to-back: finishes=%0d at %0d (%016h) and %0d (%016h)", fin_count, c1, r1, c2, r2);
        n_checks++; if (c1 !== 57) $display("FAIL b2b_first_cycle got=%0d want=57", c1); else n_pass++;
        n_checks++; if (c2 !== 114) $display("FAIL b2b_second_cycle got=%0d want=114", c2); else n_pass++;
        n_checks++; if (r1 !== 64'h4008_0000_0000_0000) $display("FAIL b2b_first_result got=%016h want=4008000000000000", r1); else n_pass++;
        n_checks++; if (r2 !== 64'h3FF8_0000_0000_0002) $display("FAIL b2b_second_result got=%016h want=3ff8000000000002", r2); else n_pass++;
        n_checks++; if (fin_count !== 2) $display("FAIL b2b_finish_count got=%0d want=2", fin_count); else n_pass++;
    endtask

    // Reset in cycle 30 aborts the request. No finish may ever appear for it.
    task automatic test_reset_mid();
        int fin_count;
        fin_count = 0;
        @(posedge clk); #1;
        bus.valid = 1'b1;
        bus.a     = 64'h4010_0000_0000_0000;
        bus.b     = 64'h4014_0000_0000_0000;
        for (int n = 1; n <= 140; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.valid = 1'b0;
            if (bus.finish === 1'b1) fin_count++;
            if (n == 30) begin
                rst_n = 1'b0;
                #1;
                n_checks++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy got=%b want=0", bus.busy); else n_pass++;
                n_checks++; if (bus.result !== 64'd0) $display("FAIL midreset_result got=%016h want=0", bus.result); else n_pass++;
                n_checks++; if (bus.flags !== 3'b000) $display("FAIL midreset_flags got=%03b want=000", bus.flags); else n_pass++;
            end
            if (n == 33) rst_n = 1'b1;
        end
        $display("op reset-abort: finishes after abort=%0d", fin_count);
        n_checks++; if (fin_count !== 0) $display("FAIL midreset_no_finish got=%0d want=0", fin_count); else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] x, y, r, er;
        logic [2:0]  f, ef;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            x = rand_operand();
            y = rand_operand();
            ref_mul(x, y, er, ef);
            do_op(x, y, r, f, lat);
            n_checks++; if (r !== er) $display("FAIL random_result_%0d a=%016h b=%016h got=%016h want=%016h", i, x, y, r, er); else n_pass++;
            n_checks++; if (f !== ef) $display("FAIL random_flags_%0d a=%016h b=%016h got=%03b want=%03b", i, x, y, f, ef); else n_pass++;
            n_checks++; if (lat !== 57) $display("FAIL random_latency_%0d got=%0d want=57", i, lat); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic();
        test_rounding();
        test_exceptions();
        test_ignored_valid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_iter.md
Name: fp_mul_iter

Overview:
- Multi-cycle IEEE-754 double-precision multiplier. Acts as the responder side of the team's valid/finish arithmetic handshake used by the CMU covariance-update FSMs.
- A requester pulses valid with operands a/b. The block returns result with a single-cycle finish pulse after a fixed latency.
- The datapath is one shared radix-2 shift-add mantissa engine, giving a small area suitable for per-CMU instantiation.

Parameters:
- DBL_WIDTH, 64, operand/result width. Only 64 (binary64) is supported; any other value is a synthesis error.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- valid  input  1  request strobe; a/b are sampled in the same cycle
- a  input  DBL_WIDTH  operand A, binary64
- b  input  DBL_WIDTH  operand B, binary64
- result  output  DBL_WIDTH  product, binary64, registered
- finish  output  1  one-cycle pulse; result is valid in this cycle
- busy  output  1  high while an operation is in flight
- flags  output  3  {invalid, overflow, underflow}, registered together with result

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. On reset, result=0, finish=0, busy=0, flags=0, state=S_IDLE.
- Handshake:
  - valid is sampled only in S_IDLE.
  - valid high in cycle 0 means finish is high in exactly cycle 57, for all operand classes (fixed latency, no fast path).
  - finish is high for exactly 1 cycle.
  - result and flags hold their value until the next finish or reset.
- busy is high in cycles 1..56.
- valid while busy is ignored: no queueing, no error.
- valid in the finish cycle (state has returned to S_IDLE) is accepted and starts a new operation.
- FSM:
  - S_IDLE: on valid, latch a and b, then go to S_UNPACK.
  - S_UNPACK (1 cycle):
    - extract sign = sa^sb, exponents ea and eb, and 53-bit mantissas with the hidden bit;
    - inputs with exp=0 are treated as zero (subnormal inputs flush to zero);
    - classify NaN/inf/zero;
    - clear the 106-bit product accumulator and the 6-bit counter.
  - S_MUL (53 cycles, counter 0..52): if multiplier bit[counter] is set, add (multiplicand << counter) to the accumulator.
  - S_NORM (1 cycle):
    - if product bit105=1, take bits 105:53 as the mantissa and set exp = ea+eb-1022; otherwise take 104:52 and set exp = ea+eb-1023;
    - derive guard bit, round bit and sticky (OR of all remaining lower bits).
  - S_ROUND (1 cycle):
    - round-to-nearest-even;
    - mantissa carry-out shifts right and increments exp;
    - pack the result, register result/flags, and pulse finish;
    - return to S_IDLE.
- Exponent arithmetic uses signed 13-bit values; it never wraps.
- Result rules, in priority order:
  - any NaN input, or inf×0: result 0x7FF8000000000000 (canonical qNaN, sign 0), invalid=1.
  - inf×nonzero: ±inf with sign = sa^sb.
  - zero×finite: ±0 with sign = sa^sb.
  - exp ≥ 2047 after rounding: ±inf, overflow=1.
  - exp ≤ 0 after rounding: ±0, underflow=1 (results flush to zero; no subnormal outputs).
- Reset mid-operation aborts the operation: no finish is produced, and outputs go to their reset values.

Test Plan:
- 0x3FF8000000000000 × 0x4000000000000000 (1.5×2.0), valid in cycle 0 → cycle 57: finish=1, result=0x4008000000000000, flags=0; cycle 58: finish=0, result held.
- Rounding:
  - 0x3FF0000000000001 × 0x3FF0000000000001 → 0x3FF0000000000002 (below half);
  - 0x3FF0000000000001 × 0x3FF8000000000000 → 0x3FF8000000000002 (exact tie, RNE rounds to even).
- Overflow: 0x7FE0000000000000 × 0x4000000000000000 → 0x7FF0000000000000, flags=3'b010.
- Invalid: 0x7FF0000000000000 × 0x0000000000000000 → 0x7FF8000000000000, flags=3'b100.
- Underflow: 0x0010000000000000 × 0x3FE0000000000000 → 0x0000000000000000, flags=3'b001.
- Sign and zero: 0x8000000000000000 × 0x4000000000000000 → 0x8000000000000000.
- Protocol:
  - second valid in cycle 10 with different operands is ignored; only one finish occurs (cycle 57), carrying the first result;
  - back-to-back valid in cycle 57 yields finish in cycle 114;
  - rst_n low in cycle 30 → busy=0 immediately and no finish ever appears for that request.
